// File: rtl/io_mem_arb_pkg.sv
// Shared definitions for the multi-channel Avalon-MM memory front end:
// FSM encodings and burst-length helpers.
package io_mem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t WR      = 2'd1;
  localparam state_t RD_CMD  = 2'd2;
  localparam state_t RD_DATA = 2'd3;

  // The burstcount MSB is reserved, so the longest burst is half the field range.
  function automatic int maxb(input int bcw);
    return 1 << (bcw - 1);
  endfunction

  function automatic int clip_len(input int len, input int max_beats);
    return (len > max_beats) ? max_beats : len;
  endfunction

endpackage

// File: rtl/io_mem_rr_arbiter.sv
// Round-robin request arbiter: the channel after the last accepted one has
// top priority; the pointer only moves when the caller accepts the grant.
module io_mem_rr_arbiter #(
  parameter int NCH = 4,
  parameter int IW  = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] req,
  input  logic           accept,
  output logic [NCH-1:0] grant,
  output logic [IW-1:0]  grant_idx,
  output logic           grant_any
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = IW'((int'(ptr) + k) % NCH);
      if (!grant_any && req[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= IW'((int'(grant_idx) + 1) % NCH);
    end
  end

endmodule

// File: rtl/io_mem_arbiter.sv
// Shares one Avalon-MM burst master between NCH fabric clients; one burst
// is outstanding at a time and read data is steered back to its owner.
module io_mem_arbiter
  import io_mem_arb_pkg::*;
#(
  parameter int NCH = 4,
  parameter int AW  = 29,
  parameter int DW  = 64,
  parameter int BCW = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [NCH-1:0]    ch_cmd_valid,
  output logic [NCH-1:0]    ch_cmd_ready,
  input  logic [NCH-1:0]    ch_cmd_write,
  input  logic [NCH*AW-1:0] ch_cmd_addr,
  input  logic [NCH*BCW-1:0] ch_cmd_len,
  input  logic [NCH*DW-1:0] ch_wdata,
  output logic [NCH-1:0]    ch_wready,
  output logic [DW-1:0]     ch_rdata,
  output logic [NCH-1:0]    ch_rvalid,
  output logic [AW-1:0]     avm_address,
  output logic [BCW-1:0]    avm_burstcount,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DW-1:0]     avm_writedata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  input  logic [DW-1:0]     avm_readdata
);

  localparam int IW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int MAXB = maxb(BCW);

  state_t          state;
  logic [IW-1:0]   owner;
  logic [AW-1:0]   addr_q;
  logic [BCW-1:0]  len_q;
  logic [BCW-1:0]  beat;
  logic [NCH-1:0]  grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic            accept;
  logic [BCW-1:0]  req_len;
  logic            last_beat;

  // No grant is handed out while reset is held, so nothing is accepted and lost.
  assign accept    = (state == IDLE) && grant_any && !reset_reset;
  assign req_len   = ch_cmd_len[grant_idx*BCW +: BCW];
  assign last_beat = (beat == len_q - BCW'(1));

  io_mem_rr_arbiter #(
    .NCH(NCH),
    .IW (IW)
  ) u_rr (
    .clk      (clk_clk),
    .reset    (reset_reset),
    .req      (ch_cmd_valid),
    .accept   (accept),
    .grant    (grant),
    .grant_idx(grant_idx),
    .grant_any(grant_any)
  );

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state  <= IDLE;
      owner  <= '0;
      addr_q <= '0;
      len_q  <= '0;
      beat   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Zero-length commands are consumed here without touching the bus.
          if (accept && (req_len != '0)) begin
            owner  <= grant_idx;
            addr_q <= ch_cmd_addr[grant_idx*AW +: AW];
            len_q  <= BCW'(clip_len(int'(req_len), MAXB));
            beat   <= '0;
            state  <= ch_cmd_write[grant_idx] ? WR : RD_CMD;
          end
        end
        WR: begin
          if (!avm_waitrequest) begin
            if (last_beat) begin
              beat  <= '0;
              state <= IDLE;
            end else begin
              beat <= beat + BCW'(1);
            end
          end
        end
        RD_CMD: begin
          if (!avm_waitrequest) state <= RD_DATA;
        end
        RD_DATA: begin
          if (avm_readdatavalid) begin
            if (last_beat) begin
              beat  <= '0;
              state <= IDLE;
            end else begin
              beat <= beat + BCW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ch_cmd_ready = accept ? grant : '0;
    ch_wready    = '0;
    ch_rvalid    = '0;
    if ((state == WR) && !avm_waitrequest && !reset_reset) ch_wready[owner] = 1'b1;
    if ((state == RD_DATA) && avm_readdatavalid && !reset_reset) ch_rvalid[owner] = 1'b1;
  end

  assign avm_write      = (state == WR);
  assign avm_read       = (state == RD_CMD);
  assign avm_address    = addr_q;
  assign avm_burstcount = len_q;
  assign avm_writedata  = (state == WR) ? ch_wdata[owner*DW +: DW] : '0;
  assign ch_rdata       = avm_readdata;

endmodule

// File: tb/tb_io_mem_arbiter.sv
// Directed self-checking bench for io_mem_arbiter: write/read bursts,
// round-robin order, length boundaries, spurious read data and mid-burst reset.
module tb_io_mem_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 29;
  localparam int DW  = 64;
  localparam int BCW = 4;

  logic               clk_clk = 1'b0;
  logic               reset_reset = 1'b1;
  logic [NCH-1:0]     ch_cmd_valid;
  logic [NCH-1:0]     ch_cmd_ready;
  logic [NCH-1:0]     ch_cmd_write;
  logic [NCH*AW-1:0]  ch_cmd_addr;
  logic [NCH*BCW-1:0] ch_cmd_len;
  logic [NCH*DW-1:0]  ch_wdata;
  logic [NCH-1:0]     ch_wready;
  logic [DW-1:0]      ch_rdata;
  logic [NCH-1:0]     ch_rvalid;
  logic [AW-1:0]      avm_address;
  logic [BCW-1:0]     avm_burstcount;
  logic               avm_read;
  logic               avm_write;
  logic [DW-1:0]      avm_writedata;
  logic               avm_waitrequest;
  logic               avm_readdatavalid;
  logic [DW-1:0]      avm_readdata;

  int tests = 0;
  int failures = 0;

  always #5 clk_clk = ~clk_clk;

  io_mem_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .BCW(BCW)) dut (
    .clk_clk          (clk_clk),
    .reset_reset      (reset_reset),
    .ch_cmd_valid     (ch_cmd_valid),
    .ch_cmd_ready     (ch_cmd_ready),
    .ch_cmd_write     (ch_cmd_write),
    .ch_cmd_addr      (ch_cmd_addr),
    .ch_cmd_len       (ch_cmd_len),
    .ch_wdata         (ch_wdata),
    .ch_wready        (ch_wready),
    .ch_rdata         (ch_rdata),
    .ch_rvalid        (ch_rvalid),
    .avm_address      (avm_address),
    .avm_burstcount   (avm_burstcount),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata     (avm_readdata)
  );

  function automatic logic [NCH-1:0] onehot(input int ch);
    return NCH'(1) << ch;
  endfunction

  function automatic logic [DW-1:0] wword(input int ch, input int k);
    return {32'hA5A5_0000, 16'(ch), 16'(k)};
  endfunction

  task automatic idle_inputs();
    ch_cmd_valid      = '0;
    ch_cmd_write      = '0;
    ch_cmd_addr       = '0;
    ch_cmd_len        = '0;
    ch_wdata          = '0;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
  endtask

  task automatic do_reset();
    reset_reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk_clk);
    #1 reset_reset = 1'b0;
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    idle_inputs();
    ch_cmd_valid = '1;
    for (int i = 0; i < NCH; i++) ch_cmd_len[i*BCW +: BCW] = BCW'(1);
    repeat (2) @(posedge clk_clk);
    @(negedge clk_clk);
    tests++; if (ch_cmd_ready !== '0) begin failures++; $display("[TB] FAIL reset_cmd_ready got %b want 0", ch_cmd_ready); end
    tests++; if (avm_read !== 1'b0) begin failures++; $display("[TB] FAIL reset_avm_read got %b want 0", avm_read); end
    tests++; if (avm_write !== 1'b0) begin failures++; $display("[TB] FAIL reset_avm_write got %b want 0", avm_write); end
    tests++; if (avm_address !== '0) begin failures++; $display("[TB] FAIL reset_address got %h want 0", avm_address); end
    tests++; if (avm_burstcount !== '0) begin failures++; $display("[TB] FAIL reset_burstcount got %0d want 0", avm_burstcount); end
    tests++; if (avm_writedata !== '0) begin failures++; $display("[TB] FAIL reset_writedata got %h want 0", avm_writedata); end
    tests++; if (ch_wready !== '0 || ch_rvalid !== '0) begin failures++; $display("[TB] FAIL reset_wready_rvalid got %b/%b want 0/0", ch_wready, ch_rvalid); end
    @(posedge clk_clk);
    #1 reset_reset = 1'b0;
    idle_inputs();
  endtask

  // Issues a write command on one channel and follows the whole burst.
  task automatic test_write_burst(input int ch, input logic [AW-1:0] a, input int l,
                                  input int exp_beats, input string tag);
    int beats;
    int wcyc;
    int first;
    logic took;
    beats = 0; wcyc = 0; first = -1;
    ch_cmd_valid[ch] = 1'b1;
    ch_cmd_write[ch] = 1'b1;
    ch_cmd_addr[ch*AW +: AW] = a;
    ch_cmd_len[ch*BCW +: BCW] = BCW'(l);
    ch_wdata[ch*DW +: DW] = wword(ch, 0);
    avm_waitrequest = 1'b0;
    @(negedge clk_clk);
    tests++; if (ch_cmd_ready !== onehot(ch)) begin failures++; $display("[TB] FAIL %s_cmd_ready got %b want %b", tag, ch_cmd_ready, onehot(ch)); end
    tests++; if (avm_write !== 1'b0) begin failures++; $display("[TB] FAIL %s_write_at_grant got %b want 0", tag, avm_write); end
    @(posedge clk_clk);
    #1 ch_cmd_valid = '0;
    for (int cyc = 1; cyc <= exp_beats + 3; cyc++) begin
      @(negedge clk_clk);
      took = 1'b0;
      if (avm_write) begin
        wcyc++;
        if (first < 0) first = cyc;
        tests++; if (avm_address !== a) begin failures++; $display("[TB] FAIL %s_address got %h want %h", tag, avm_address, a); end
        tests++; if (avm_burstcount !== BCW'(exp_beats)) begin failures++; $display("[TB] FAIL %s_burstcount got %0d want %0d", tag, avm_burstcount, exp_beats); end
        tests++; if (avm_writedata !== wword(ch, beats)) begin failures++; $display("[TB] FAIL %s_writedata got %h want %h", tag, avm_writedata, wword(ch, beats)); end
        tests++; if (ch_wready !== onehot(ch)) begin failures++; $display("[TB] FAIL %s_wready got %b want %b", tag, ch_wready, onehot(ch)); end
        took = (ch_wready === onehot(ch));
      end else begin
        tests++; if (ch_wready !== '0) begin failures++; $display("[TB] FAIL %s_wready_idle got %b want 0", tag, ch_wready); end
      end
      @(posedge clk_clk);
      #1;
      if (took) begin
        beats++;
        ch_wdata[ch*DW +: DW] = wword(ch, beats);
      end
    end
    tests++; if (first != 1) begin failures++; $display("[TB] FAIL %s_first_write_cycle got %0d want 1", tag, first); end
    tests++; if (wcyc != exp_beats) begin failures++; $display("[TB] FAIL %s_write_cycles got %0d want %0d", tag, wcyc, exp_beats); end
    tests++; if (beats != exp_beats) begin failures++; $display("[TB] FAIL %s_wready_count got %0d want %0d", tag, beats, exp_beats); end
  endtask

  task automatic test_single_write();
    test_write_burst(1, AW'(32'h100), 4, 4, "single_write");
  endtask

  task automatic test_read_latency();
    logic [11:0] pat;
    int rd_cyc;
    int pulses;
    int sent;
    pat = 12'b1011_0011_1011;
    rd_cyc = 0; pulses = 0; sent = 0;
    ch_cmd_valid[2] = 1'b1;
    ch_cmd_write[2] = 1'b0;
    ch_cmd_addr[2*AW +: AW] = AW'(32'h40);
    ch_cmd_len[2*BCW +: BCW] = BCW'(8);
    avm_waitrequest = 1'b1;
    @(negedge clk_clk);
    tests++; if (ch_cmd_ready !== 4'b0100) begin failures++; $display("[TB] FAIL read_cmd_ready got %b want 0100", ch_cmd_ready); end
    @(posedge clk_clk);
    #1 ch_cmd_valid = '0;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      avm_waitrequest = (cyc <= 3);
      avm_readdatavalid = (cyc >= 5 && cyc <= 16) ? pat[11 - (cyc - 5)] : 1'b0;
      avm_readdata = 64'hD00D_0000_0000_0000 + 64'(sent);
      @(negedge clk_clk);
      if (avm_read) begin
        rd_cyc++;
        tests++; if (avm_address !== AW'(32'h40) || avm_burstcount !== BCW'(8)) begin failures++; $display("[TB] FAIL read_cmd_fields got %h/%0d want 40/8", avm_address, avm_burstcount); end
      end
      if (ch_rvalid[2]) pulses++;
      if (avm_readdatavalid) begin
        tests++; if (ch_rvalid !== 4'b0100) begin failures++; $display("[TB] FAIL read_rvalid got %b want 0100", ch_rvalid); end
        tests++; if (ch_rdata !== 64'hD00D_0000_0000_0000 + 64'(sent)) begin failures++; $display("[TB] FAIL read_rdata got %h want %h", ch_rdata, 64'hD00D_0000_0000_0000 + 64'(sent)); end
        sent++;
      end else begin
        tests++; if (ch_rvalid !== '0) begin failures++; $display("[TB] FAIL read_rvalid_gap got %b want 0", ch_rvalid); end
      end
      @(posedge clk_clk);
      #1;
    end
    avm_readdatavalid = 1'b0;
    avm_waitrequest = 1'b0;
    tests++; if (rd_cyc != 4) begin failures++; $display("[TB] FAIL read_strobe_cycles got %0d want 4", rd_cyc); end
    tests++; if (pulses != 8) begin failures++; $display("[TB] FAIL read_rvalid_count got %0d want 8", pulses); end
  endtask

  task automatic test_fairness();
    int n;
    int order [6];
    int last;
    int idx;
    logic pending;
    logic next_rdv;
    n = 0; last = 0; pending = 1'b0;
    for (int i = 0; i < 6; i++) order[i] = -1;
    do_reset();
    ch_cmd_valid = '1;
    ch_cmd_write = '0;
    avm_waitrequest = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      ch_cmd_len[i*BCW +: BCW] = BCW'(1);
      ch_cmd_addr[i*AW +: AW] = AW'(32'h1000 + i);
    end
    for (int cyc = 0; cyc < 30; cyc++) begin
      avm_readdatavalid = pending;
      avm_readdata = 64'hFA00 + 64'(last);
      @(negedge clk_clk);
      next_rdv = avm_read;
      if (avm_read) begin
        tests++; if (avm_address !== AW'(32'h1000 + last)) begin failures++; $display("[TB] FAIL fair_address got %h want %h", avm_address, AW'(32'h1000 + last)); end
      end
      if (ch_cmd_ready !== '0) begin
        idx = 0;
        for (int j = 0; j < NCH; j++) if (ch_cmd_ready[j]) idx = j;
        tests++; if (ch_cmd_ready !== onehot(idx)) begin failures++; $display("[TB] FAIL fair_onehot got %b want %b", ch_cmd_ready, onehot(idx)); end
        if (n < 6) order[n] = idx;
        n++;
        last = idx;
      end
      if (pending) begin
        tests++; if (ch_rvalid !== onehot(last)) begin failures++; $display("[TB] FAIL fair_rvalid got %b want %b", ch_rvalid, onehot(last)); end
        tests++; if (ch_rdata !== 64'hFA00 + 64'(last)) begin failures++; $display("[TB] FAIL fair_rdata got %h want %h", ch_rdata, 64'hFA00 + 64'(last)); end
      end
      @(posedge clk_clk);
      #1;
      pending = next_rdv;
      if (n >= 6) ch_cmd_valid = '0;
    end
    avm_readdatavalid = 1'b0;
    tests++; if (n != 6) begin failures++; $display("[TB] FAIL fair_grant_count got %0d want 6", n); end
    for (int i = 0; i < 6; i++) begin
      tests++; if (order[i] != i % NCH) begin failures++; $display("[TB] FAIL fair_order[%0d] got %0d want %0d", i, order[i], i % NCH); end
    end
  endtask

  task automatic test_boundary_len();
    ch_cmd_write = '0;
    ch_cmd_len = '0;
    ch_cmd_valid = 4'b0001;
    @(negedge clk_clk);
    tests++; if (ch_cmd_ready !== 4'b0001) begin failures++; $display("[TB] FAIL len0_cmd_ready got %b want 0001", ch_cmd_ready); end
    @(posedge clk_clk);
    #1 ch_cmd_valid = 4'b0011;
    @(negedge clk_clk);
    tests++; if (ch_cmd_ready !== 4'b0010) begin failures++; $display("[TB] FAIL len0_rotate got %b want 0010", ch_cmd_ready); end
    @(posedge clk_clk);
    #1 ch_cmd_valid = '0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk_clk);
      tests++; if (avm_read !== 1'b0 || avm_write !== 1'b0) begin failures++; $display("[TB] FAIL len0_no_strobe got %b%b want 00", avm_read, avm_write); end
      @(posedge clk_clk);
      #1;
    end
    test_write_burst(3, AW'(32'h1F0), 15, 8, "len15");
  endtask

  task automatic test_spurious();
    ch_cmd_valid = '0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = 64'hBAD0 + 64'(cyc);
      @(negedge clk_clk);
      tests++; if (ch_rvalid !== '0) begin failures++; $display("[TB] FAIL spurious_rvalid got %b want 0", ch_rvalid); end
      @(posedge clk_clk);
      #1;
    end
    avm_readdatavalid = 1'b0;
  endtask

  task automatic test_reset_midburst();
    int wcount;
    wcount = 0;
    ch_cmd_valid[1] = 1'b1;
    ch_cmd_write[1] = 1'b1;
    ch_cmd_addr[1*AW +: AW] = AW'(32'h200);
    ch_cmd_len[1*BCW +: BCW] = BCW'(4);
    ch_wdata[1*DW +: DW] = wword(1, 0);
    avm_waitrequest = 1'b0;
    @(negedge clk_clk);
    tests++; if (ch_cmd_ready !== 4'b0010) begin failures++; $display("[TB] FAIL rst_cmd_ready got %b want 0010", ch_cmd_ready); end
    @(posedge clk_clk);
    #1 ch_cmd_valid = '0;
    for (int cyc = 1; cyc <= 2; cyc++) begin
      @(negedge clk_clk);
      tests++; if (avm_write !== 1'b1 || ch_wready !== 4'b0010) begin failures++; $display("[TB] FAIL rst_beat%0d got write=%b wready=%b want 1/0010", cyc, avm_write, ch_wready); end
      if (ch_wready[1]) wcount++;
      @(posedge clk_clk);
      #1;
    end
    reset_reset = 1'b1;
    avm_waitrequest = 1'b1;
    @(negedge clk_clk);
    if (ch_wready[1]) wcount++;
    @(posedge clk_clk);
    #1;
    reset_reset = 1'b0;
    avm_waitrequest = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk_clk);
      tests++; if (avm_write !== 1'b0 || avm_read !== 1'b0) begin failures++; $display("[TB] FAIL rst_strobes got %b%b want 00", avm_write, avm_read); end
      if (ch_wready[1]) wcount++;
      @(posedge clk_clk);
      #1;
    end
    tests++; if (wcount != 2) begin failures++; $display("[TB] FAIL rst_wready_count got %0d want 2", wcount); end
    ch_cmd_len = '0;
    ch_cmd_valid = 4'b1010;
    @(negedge clk_clk);
    tests++; if (ch_cmd_ready !== 4'b0010) begin failures++; $display("[TB] FAIL rst_pointer got %b want 0010", ch_cmd_ready); end
    @(posedge clk_clk);
    #1 ch_cmd_valid = '0;
    test_write_burst(1, AW'(32'h300), 2, 2, "after_reset");
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_read_latency();
    test_fairness();
    test_boundary_len();
    test_spurious();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/io_mem_arbiter.md
# io_mem_arbiter

Parametrised multi-channel front end for the HPS SDRAM Avalon-MM port. It lets NCH fabric clients (solver cores, result writers) share one memory master. Requests are arbitrated round-robin, and each grant becomes a single Avalon burst read or write. Read data is routed back to the owning channel. It sits between the numerical datapath and the memory bridge exported by the memory subsystem.

## Interface
Parameters:
- NCH, 4: number of client channels (1..8)
- AW, 29: word address width
- DW, 64: data width
- BCW, 4: burstcount width; MAXB = 2^(BCW-1) = 8 beats

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  reset, synchronous, active-high
- ch_cmd_valid  in  NCH  per-channel command request
- ch_cmd_ready  out  NCH  one-hot pulse: command accepted this cycle
- ch_cmd_write  in  NCH  1 = write burst, 0 = read burst
- ch_cmd_addr  in  NCH*AW  start word address, channel i at [i*AW +: AW]
- ch_cmd_len  in  NCH*BCW  beats requested
- ch_wdata  in  NCH*DW  write word currently offered by each channel
- ch_wready  out  NCH  one-hot pulse: offered write word consumed
- ch_rdata  out  DW  read data, shared by all channels
- ch_rvalid  out  NCH  one-hot: ch_rdata valid for that channel
- avm_address, avm_burstcount  out  AW, BCW  Avalon-MM burst address and length
- avm_read, avm_write  out  1  Avalon-MM strobes
- avm_writedata  out  DW  Avalon-MM write data
- avm_waitrequest, avm_readdatavalid  in  1  Avalon-MM flow control
- avm_readdata  in  DW  Avalon-MM read data

## Operation
- FSM states: IDLE, WR, RD_CMD, RD_DATA. Exactly one transaction is outstanding at any time.
- IDLE:
  - If any ch_cmd_valid is high, grant the round-robin winner and pulse its ch_cmd_ready.
  - Latch addr, len and write; latch owner = winner index.
  - Go to WR or RD_CMD.
- Round-robin: the channel after the last granted one has highest priority. After reset, channel 0 has highest priority.
- Length rules:
  - len = 0: accept and discard. Pulse cmd_ready, no bus activity, stay in IDLE, rotate pointer.
  - len > MAXB: clip to MAXB.
- WR:
  - avm_write = 1, avm_writedata = ch_wdata[owner], address and burstcount held constant for the whole burst.
  - Each cycle with avm_waitrequest = 0 is one accepted beat. Pulse ch_wready[owner] in that cycle and increment the beat counter.
  - After the last beat, go to IDLE.
- RD_CMD: avm_read = 1 until avm_waitrequest = 0, then go to RD_DATA.
- RD_DATA:
  - For each avm_readdatavalid: ch_rdata = avm_readdata and ch_rvalid[owner] = 1, combinational pass-through.
  - After len beats, go to IDLE.
- avm_readdatavalid outside RD_DATA is ignored and never forwarded.
- ch_cmd_valid deasserting while a channel waits has no effect. Command fields of non-granted channels are never sampled.

## Timing
- Reset values: ch_cmd_ready = 0, ch_wready = 0, ch_rvalid = 0, avm_read = 0, avm_write = 0, avm_address = 0, avm_burstcount = 0, avm_writedata = 0, FSM = IDLE, rr pointer = 0, beat counter = 0.
- Command accepted (cmd_ready) in cycle N; avm_read or avm_write first asserted in cycle N+1.
- Minimum write burst of L beats: L cycles on the bus, then IDLE; next grant no earlier than 1 cycle later.
- Read data latency is avm latency + 0 cycles.
- Back-to-back commands: IDLE always lasts at least 1 cycle between transactions.
- Reset mid-burst:
  - All strobes drop the next cycle. The partial burst is abandoned, and no further ch_wready or ch_rvalid pulses occur.
  - The memory side must be reset by the same system reset.
- Simultaneous requests from all channels under continuous valid: grants follow 0,1,2,3,0 and so on.

## Structure
- Package io_mem_arb_pkg holds:
  - FSM state enum
  - MAXB as a function of BCW
  - helper clip_len()
- Sub-module io_mem_rr_arbiter (NCH-wide request in; one-hot grant plus index out; pointer update on an accept strobe) is instantiated once.

## Test plan
- Single write: ch1 addr 0x100, len 4, waitrequest low. Required: avm_write for 4 cycles at burstcount 4, address 0x100; ch_wready[1] pulses 4 times; words written in order.
- Read with latency: ch2 addr 0x40, len 8, waitrequest high 3 cycles, then readdatavalid 8 times with gaps. Required: avm_read held 4 cycles; exactly 8 ch_rvalid[2] pulses carrying matching data.
- Fairness: all 4 channels hold valid with len 1 reads. Required: grant order 0,1,2,3,0,1, and no channel starved.
- Boundary lengths:
  - len 0 on ch0: cmd_ready pulse, no avm strobe.
  - len 15 on ch3: burstcount 8, 8 beats.
- Spurious and reset cases:
  - readdatavalid in IDLE: no ch_rvalid.
  - reset_reset asserted at write beat 2 of 4: strobes 0 next cycle, pointer back to 0, later command proceeds normally.
